// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/collect sequencer for the external pipelined
// 32x32->64 unsigned multiplier IP. Feeds the IP with operand magnitudes,
// waits its fixed latency, applies the sign fix for MULH.W and holds the
// selected 32-bit result until the consumer takes it.
module mul_issue_ctrl #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p
);

  localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             neg_q;

  logic             is_mulh_s;
  logic [31:0]      mag1;
  logic [31:0]      mag2;
  logic [63:0]      prod_fix;
  logic [31:0]      prod_sel;

  // Operand conditioning (magnitudes for signed-high op) and product fix-up
  always_comb begin
    is_mulh_s = (in_op == 2'b01);
    mag1      = in_src1;
    mag2      = in_src2;
    if (is_mulh_s && in_src1[31]) mag1 = ~in_src1 + 32'd1;
    if (is_mulh_s && in_src2[31]) mag2 = ~in_src2 + 32'd1;
    prod_fix  = neg_q ? (~mul_p + 64'd1) : mul_p;
    prod_sel  = ((op_q == 2'b01) || (op_q == 2'b10)) ? prod_fix[63:32]
                                                     : prod_fix[31:0];
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Issue/wait/hold sequencer; flush overrides every state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mul_a <= mag1;
            mul_b <= mag2;
            op_q  <= in_op;
            neg_q <= is_mulh_s & (in_src1[31] ^ in_src2[31]);
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == CNT_W'(MUL_LATENCY)) begin
            out_result <= prod_sel;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Testbench for mul_issue_ctrl: models the multiplier IP as a pipeline,
// drives directed ops and checks results/latency through a scoreboard.
module tb_mul_issue_ctrl;

  localparam int unsigned MUL_LATENCY = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  bit          prev_valid = 1'b0;
  bit          prev_hs = 1'b0;
  logic [63:0] ip_pipe [MUL_LATENCY];

  mul_issue_ctrl #(.MUL_LATENCY(MUL_LATENCY)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier IP model: unsigned product delayed MUL_LATENCY cycles
  always @(posedge clk) begin
    ip_pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int i = 1; i < MUL_LATENCY; i++) ip_pipe[i] <= ip_pipe[i-1];
  end
  assign mul_p = ip_pipe[MUL_LATENCY-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (!resetn) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) chk("valid_one_cycle", {63'd0, out_valid}, 64'd0);
      if (out_valid && !prev_valid) begin
        rise_cyc = cyc;
        chk("valid_expected", {63'd0, sb.size() != 0}, 64'd1);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {32'd0, out_result}, {32'd0, e.res});
        chk("latency", 64'(rise_cyc), 64'(e.cyc));
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input bit expect_result);
    int unsigned n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("issue_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (expect_result) sb.push_back('{exp_res, cyc + MUL_LATENCY + 1});
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((sb.size() != 0 || out_valid || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_src1   = '0;
    in_src2   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_mul_a", {32'd0, mul_a}, 64'd0);
    chk("rst_mul_b", {32'd0, mul_b}, 64'd0);
    chk("rst_out_result", {32'd0, out_result}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Basic ops and sign handling
    issue(2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b1);
    wait_idle();
    issue(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
    chk("mul_a_mag", {32'd0, mul_a}, 64'h80000000);
    wait_idle();
    issue(2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1);
    chk("mul_a_neg_mag", {32'd0, mul_a}, 64'd1);
    wait_idle();
    issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1);
    wait_idle();
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    wait_idle();
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    wait_idle();
    issue(2'b11, 32'h00010000, 32'h00010003, 32'h00030000, 1'b1);
    wait_idle();
    issue(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b1);
    wait_idle();
    issue(2'b01, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b1);
    wait_idle();

    // Backpressure in DONE
    out_ready = 1'b0;
    issue(2'b10, 32'h80000000, 32'h00000004, 32'h00000002, 1'b1);
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", {63'd0, out_valid}, 64'd1);
      chk("bp_result_hold", {32'd0, out_result}, 64'd2);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_src1  = 32'd11;
      in_src2  = 32'd13;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Flush one cycle into BUSY
    issue(2'b00, 32'd9, 32'd9, 32'd0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("flush_no_valid", {63'd0, out_valid}, 64'd0);
    end
    issue(2'b00, 32'd3, 32'd5, 32'h0000000F, 1'b1);
    wait_idle();

    // Asynchronous reset mid-BUSY
    issue(2'b00, 32'd5, 32'd9, 32'd0, 1'b0);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_mul_a", {32'd0, mul_a}, 64'd0);
    chk("arst_mul_b", {32'd0, mul_b}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("arst_no_valid", {63'd0, out_valid}, 64'd0);
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
